// File: rtl/simon_cipher_algorithm_core.sv
// One SIMON encryption round per clock, with the round key derived combinationally
// from the master key and a round index that saturates at the last round.
module simon_cipher_algorithm_core #(
  parameter int N = 48,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] x,
  input  logic [N*M-1:0] key,
  input  logic [6:0]     round,
  output logic [2*N-1:0] y
);

  function automatic int rounds_for(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  // Leftmost literal bit is sequence element 0.
  function automatic logic [61:0] zseq_for(input int n, input int m);
    logic [61:0] z0, z1, z2, z3, z4;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    if ((n == 16 && m == 4) || (n == 24 && m == 3)) return z0;
    if (n == 24 && m == 4) return z1;
    if ((n == 32 && m == 3) || (n == 48 && m == 2) || (n == 64 && m == 2)) return z2;
    if ((n == 32 && m == 4) || (n == 48 && m == 3) || (n == 64 && m == 3)) return z3;
    return z4;
  endfunction

  localparam int T = rounds_for(N, M);
  localparam logic [61:0] ZSEQ = zseq_for(N, M);

  if (T == 0) begin : g_unsupported
    $error("simon_cipher_algorithm_core: unsupported (N, M) pair");
  end

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
    return (a >> s) | (a << (N - s));
  endfunction

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  function automatic logic [N-1:0] zbit(input int j);
    logic [N-1:0] zv;
    zv    = '0;
    zv[0] = ZSEQ[61 - (j % 62)];
    return zv;
  endfunction

  // Full schedule unrolled up to T-1; only the selected word leaves the function.
  function automatic logic [N-1:0] round_key(input logic [N*M-1:0] k, input int r);
    logic [N-1:0] kk [T];
    logic [N-1:0] tmp;
    for (int i = 0; i < T; i++) begin
      if (i < M) begin
        kk[i] = k[i*N +: N];
      end else begin
        tmp = ror(kk[(i > 0) ? i - 1 : 0], 3);
        if (M == 4) tmp = tmp ^ kk[(i >= 3) ? i - 3 : 0];
        tmp = tmp ^ ror(tmp, 1);
        kk[i] = ~kk[(i >= M) ? i - M : 0] ^ tmp ^ zbit(i - M) ^ N'(3);
      end
    end
    return kk[r];
  endfunction

  logic [6:0]     round_c;
  logic [N-1:0]   key_i;
  logic [N-1:0]   x_hi;
  logic [N-1:0]   x_lo;
  logic [2*N-1:0] y_next;
  logic [2*N-1:0] y_p0;

  assign round_c = (int'(round) > T - 1) ? 7'(T - 1) : round;
  assign key_i   = round_key(key, int'(round_c));
  assign x_hi    = x[2*N-1:N];
  assign x_lo    = x[N-1:0];
  assign y_next  = {x_lo ^ simon_f(x_hi) ^ key_i, x_hi};

  // ---- stage p0: round result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_p0 <= '0;
    else     y_p0 <= y_next;
  end

  assign y = y_p0;

endmodule

// File: tb/tb_simon_cipher_algorithm_core.sv
// Bench for the SIMON 96/96 round core: constant vectors, known-answer chain,
// round clamping, per-cycle random traffic and asynchronous reset.
module tb_simon_cipher_algorithm_core;
  localparam int N = 48;
  localparam int M = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [95:0]   x   = '0;
  logic [95:0]   key = '0;
  logic [6:0]    round = '0;
  logic [95:0]   y;

  always #5 clk = ~clk;

  simon_cipher_algorithm_core #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .key   (key),
    .round (round),
    .y     (y)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [95:0] exp_q [$];
  logic [47:0] sched [52];
  logic [61:0] z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef struct {
    logic [95:0] x;
    logic [95:0] key;
    logic [6:0]  round;
    logic [47:0] ki;
    logic [95:0] y;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [47:0] mrol(input logic [47:0] a, input int s);
    return (a << s) | (a >> (48 - s));
  endfunction

  function automatic logic [47:0] mror(input logic [47:0] a, input int s);
    return (a >> s) | (a << (48 - s));
  endfunction

  // Reference schedule in the classic constant form c = 2^n - 4.
  task automatic expand(input logic [95:0] k);
    logic [47:0] c;
    logic [47:0] zb;
    c = 48'hFFFF_FFFF_FFFC;
    sched[0] = k[47:0];
    sched[1] = k[95:48];
    for (int i = 2; i < 52; i++) begin
      zb = '0;
      zb[0] = z2[61 - (i - 2)];
      sched[i] = c ^ zb ^ sched[i-2] ^ mror(sched[i-1], 3) ^ mror(sched[i-1], 4);
    end
  endtask

  function automatic logic [95:0] model_round(input logic [95:0] xi, input logic [47:0] rk);
    logic [47:0] a, b, f;
    a = xi[95:48];
    b = xi[47:0];
    f = (mrol(a, 1) & mrol(a, 8)) ^ mrol(a, 2);
    return {b ^ f ^ rk, a};
  endfunction

  task automatic apply(input logic [95:0] xi, input logic [95:0] ki, input logic [6:0] r,
                       input string name);
    logic [47:0] rk;
    int ri;
    expand(ki);
    ri = (r > 7'd51) ? 51 : int'(r);
    rk = sched[ri];
    x = xi; key = ki; round = r;
    #1;
    check({name, " key_i"}, {48'h0, dut.key_i}, {48'h0, rk});
    exp_q.push_back(model_round(xi, rk));
    @(posedge clk); #1;
    check({name, " y"}, y, exp_q.pop_front());
  endtask

  initial begin
    logic [95:0] xs;
    logic [95:0] kat_key;
    logic [95:0] kat_pt;

    vecs[0] = '{96'h0, 96'hAAAABBBBCCCC_DDDDEEEEFFFF, 7'd0, 48'hDDDDEEEEFFFF,
                {48'hDDDDEEEEFFFF, 48'h0}};
    vecs[1] = '{96'h0, 96'hAAAABBBBCCCC_DDDDEEEEFFFF, 7'd1, 48'hAAAABBBBCCCC,
                {48'hAAAABBBBCCCC, 48'h0}};
    vecs[2] = '{{48'h1, 48'h0}, 96'h0, 7'd0, 48'h0, {48'h4, 48'h1}};
    vecs[3] = '{{48'h0, 48'h1}, 96'h0, 7'd1, 48'h0, {48'h1, 48'h0}};
    vecs[4] = '{{48'h8000_0000_0000, 48'h0}, 96'h0, 7'd0, 48'h0,
                {48'h2, 48'h8000_0000_0000}};
    vecs[5] = '{{48'hFFFF_FFFF_FFFF, 48'h0}, 96'h0, 7'd0, 48'h0,
                {48'h0, 48'hFFFF_FFFF_FFFF}};

    x = {48'h1234, 48'h5678};
    key = 96'h1;
    #2 rst = 1'b1;
    #1 check("reset immediate", y, 96'h0);
    repeat (2) @(posedge clk);
    #1 check("reset held", y, 96'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      x = vecs[i].x; key = vecs[i].key; round = vecs[i].round;
      #1;
      check($sformatf("vec%0d key_i", i), {48'h0, dut.key_i}, {48'h0, vecs[i].ki});
      exp_q.push_back(vecs[i].y);
      @(posedge clk); #1;
      check($sformatf("vec%0d y", i), y, exp_q.pop_front());
    end

    kat_key = 96'h0d0c0b0a0908_050403020100;
    kat_pt  = 96'h2072616c6c69_702065687420;
    xs = kat_pt;
    for (int r = 0; r < 52; r++) begin
      apply(xs, kat_key, 7'(r), $sformatf("kat r%0d", r));
      xs = y;
    end
    check("kat ciphertext", y, 96'h602807a462b4_69063d8ff082);

    apply(kat_pt, kat_key, 7'd52,  "clamp r52");
    apply(kat_pt, kat_key, 7'd53,  "clamp r53");
    apply(kat_pt, kat_key, 7'd90,  "clamp r90");
    apply(kat_pt, kat_key, 7'd127, "clamp r127");

    for (int c = 0; c < 10; c++) begin
      apply({$urandom, $urandom, $urandom}, (c < 5) ? kat_key : {$urandom, $urandom, $urandom},
            7'(c % 5), $sformatf("stream c%0d", c));
    end

    apply({48'hCAFE, 48'hBEEF}, kat_key, 7'd3, "pre midreset");
    @(posedge clk); #3;
    rst = 1'b1;
    #1 check("midrun reset immediate", y, 96'h0);
    @(posedge clk); #1;
    check("midrun reset held", y, 96'h0);
    rst = 1'b0;
    apply({48'h0F0F, 48'hF0F0}, kat_key, 7'd2, "after release");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1, "timeout");
  end

endmodule
